updown_counter_param: RTL



---
 rtl/irrig_pkg.sv | 10 +
 rtl/updown_counter_param_tick_gen.sv | 38 +++
 rtl/updown_counter_param.sv | 80 ++++++++
 3 files changed

// File: rtl/irrig_pkg.sv
// Shared encodings for the irrigation controller timing blocks.
package irrig_pkg;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

    localparam logic LIM_WRAP  = 1'b0;
    localparam logic LIM_SAT   = 1'b1;

endpackage

// File: rtl/updown_counter_param_tick_gen.sv
// Enable-gated prescaler: issues one step every PRESCALE enabled clocks.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With PRESCALE=1 the count is pinned at 0 == LAST, so step reduces to en.
    assign step = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down interval counter with prescaler, clamped load,
// wrap-or-saturate limiting and boundary flags.
module updown_counter_param
    import irrig_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;
    logic             step;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .step(step)
    );

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (load) begin
            q_d = (load_val > MAX_Q) ? MAX_Q : load_val;
        end else if (step) begin
            if (mode == MODE_UP) begin
                if (q_q == MAX_Q) begin
                    tc_d = 1'b1;
                    q_d  = (sat == LIM_SAT) ? MAX_Q : '0;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q == '0) begin
                    tc_d = 1'b1;
                    q_d  = (sat == LIM_SAT) ? '0 : MAX_Q;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q       = q_q;
    assign tc      = tc_q;
    assign at_zero = (q_q == '0);
    assign at_max  = (q_q == MAX_Q);

endmodule
